axi4_sub_mem: RTL and testbench
===============================

# axi4_sub_mem

AXI4 subordinate backed by an on-chip word-addressed memory. It sits directly downstream of the team's AXI4 manager (`axi4_mgr`) on an `AXI_BUS` interface, and serves as both the bench target and a synthesizable scratch memory. It accepts single-beat, FIXED and INCR bursts on independent read and write channels, one outstanding transaction per direction. Full-width beats only.

## Interface
- `AXI_ADDR_WIDTH`, 32: address width.
- `AXI_DATA_WIDTH`, 64: data width; bytes per beat `NB = AXI_DATA_WIDTH/8`.
- `MEM_DEPTH`, 256: number of `AXI_DATA_WIDTH` words; power of 2.
- `BASE_ADDR`, 0: byte address of word 0; aligned to `NB*MEM_DEPTH`.
- `clk_i`  in  1  clock; one clock domain.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `axi_sub_if`  `AXI_BUS.Slave`  all AW/W/B/AR/R channel signals.

## Operation
- Word index = `(addr - BASE_ADDR) >> $clog2(NB)`, truncated to `$clog2(MEM_DEPTH)` bits.
- Per-beat address step:
  - INCR: `NB`.
  - FIXED: 0.
  - WRAP: treated as INCR.
- `*_size` is ignored; every beat is full width.
- Write FSM `WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE`:
  - WR_IDLE: `aw_ready=1`. On AW handshake, latch addr, len, burst and id, then go to WR_DATA.
  - WR_DATA: `w_ready=1`. Each W handshake writes the bytes enabled by `w_strb`, advances the address and increments the beat count. The handshake on beat `len` (0-based) goes to WR_RESP. The beat count alone ends the burst; `w_last` does not.
  - WR_RESP: `b_valid=1`, `b_id` = latched id, `b_resp` = accumulated response. On `b_ready`, go to WR_IDLE.
- Read FSM `RD_IDLE -> RD_DATA -> RD_IDLE`:
  - RD_IDLE: `ar_ready=1`. On AR handshake, latch addr, len, burst and id.
  - RD_DATA: `r_valid=1`. `r_data` = word at the current address, `r_id` = latched id, `r_last = (beat == len)`.
  - On an R handshake: advance. After the last beat, go to RD_IDLE.
  - While `r_ready=0`, `r_data`, `r_last` and `r_resp` hold stable.
- The two FSMs are fully independent.
- `b_user` and `r_user` are tied to 0.

## Timing
- Reset values:
  - `aw_ready`, `w_ready`, `b_valid`, `ar_ready`, `r_valid`, `r_last`: 0.
  - `b_resp`, `r_resp`, `b_id`, `r_id`, `r_data`: 0.
- Memory contents are not reset.
- `aw_ready` and `ar_ready` are registered. They rise on the first clock edge after reset deassertion and fall in the cycle after their handshake.
- AW handshake at edge N: `w_ready=1` from N+1.
- Last W handshake at edge M: `b_valid=1` from M+1.
- AR handshake at edge N: first `r_valid=1` with data from N+1.
- R handshake at edge K: next beat valid at K+1, giving one beat per cycle under continuous `r_ready`.
- Read and write to the same word at the same edge: the read returns the old data.
- `len=0`: exactly one beat, and `r_last=1` on it.
- Address overflow past the end of memory wraps modulo `MEM_DEPTH`, unless `AXI4_SUB_ERR_EN` is defined.
- Reset mid-burst: both FSMs return to idle immediately, all valids drop, and no B or R is produced for the aborted transaction.
- W data arriving before the AW handshake is not accepted, because `w_ready=0` in WR_IDLE.

## Configuration
`AXI4_SUB_ERR_EN` compiles in error detection; without it, every response is OKAY (`2'b00`) and addresses wrap as above.
- Defined:
  - A beat whose address lies outside `[BASE_ADDR, BASE_ADDR+NB*MEM_DEPTH)` is not written, returns `r_data=0`, and sets SLVERR (`2'b10`).
  - WRAP bursts respond SLVERR and perform no memory access.
  - A `w_last` value that disagrees with the beat count makes `b_resp` SLVERR. Termination still follows the beat count.
  - `b_resp` is sticky across the burst: SLVERR if any beat erred.
  - `r_resp` is reported per beat.

## Structure
- Package `axi4_sub_pkg` holds:
  - `wr_state_t` and `rd_state_t` enums.
  - Constants `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`, `BURST_FIXED=2'b00`, `BURST_INCR=2'b01`, `BURST_WRAP=2'b10`.
- Sub-module `axi4_sub_mem_array` is the storage:
  - One write port with byte enables.
  - One asynchronous-index read port feeding the registered `r_data`.
  - Parameters: `AXI_DATA_WIDTH` and `MEM_DEPTH`.

## Test plan
- Single write then read: AW addr `0x10`, len 0, data `0xDEADBEEF_01234567`, strb `0xFF` -> B OKAY one cycle after W; AR `0x10` len 0 -> R returns same data with `r_last=1`.
- INCR burst: AW `0x0` len 3, data 1..4 -> AR `0x0` len 3 returns 1,2,3,4 with `r_last` on beat 3 only; then toggle `r_ready` 1,0,1 and check data is held while stalled.
- Strobe: write `0xFFFF_FFFF_FFFF_FFFF` to `0x8`, then `0x0000_0000_0000_0000` with strb `0x0F` -> read returns `0xFFFF_FFFF_0000_0000`.
- Concurrent: 4-beat write to `0x40` while 4-beat read of `0x80` -> both complete with no stall interaction and both IDs echoed (`aw_id=3`, `ar_id=5`).
- Error (`AXI4_SUB_ERR_EN`, `MEM_DEPTH=256`): AR `0x800` len 0 -> `r_resp=2'b10`, `r_data=0`; without the macro -> reads word 0, OKAY.
- Reset asserted during beat 2 of a 4-beat write -> no B; after release `aw_ready=1` one cycle later and a new write completes normally.

Source files
------------

// File: rtl/axi4_sub_pkg.sv
// Shared types and constants for the AXI4 memory subordinate.
//   wr_state_t / rd_state_t : write and read channel FSM states
//   RESP_* / BURST_*        : AXI response and burst-type encodings
//   resp_of()               : maps an error flag to an AXI response code
package axi4_sub_pkg;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned BURST_W = 2;

    localparam logic [RESP_W-1:0]  RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0]  RESP_SLVERR = 2'b10;
    localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    function automatic logic [RESP_W-1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/AXI_BUS.sv
// AXI4 bus bundle carrying the AW/W/B/AR/R channels.
//   Master modport : drives AW/W/AR and B/R ready
//   Slave modport  : drives AW/W/AR ready and the B/R channels
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi4_sub_mem_array.sv
// Word-addressed storage: one byte-enabled write port, one combinational read port.
//   clk    : write clock
//   we     : write enable, w_idx/w_data/w_strb : write word index, data, byte enables
//   r_idx  : read word index, r_data : word at r_idx (combinational)
module axi4_sub_mem_array #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned MEM_DEPTH      = 256
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] w_idx,
    input  logic [AXI_DATA_WIDTH-1:0]    w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]  w_strb,
    input  logic [$clog2(MEM_DEPTH)-1:0] r_idx,
    output logic [AXI_DATA_WIDTH-1:0]    r_data
);
    localparam int unsigned NB = AXI_DATA_WIDTH / 8;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Byte-lane write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_strb[b]) begin
                    mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
    end

    // Read is sampled by the caller's registered r_data, so a same-edge write returns old data
    assign r_data = mem[r_idx];

endmodule

// File: rtl/axi4_sub_mem.sv
// AXI4 subordinate backed by on-chip memory; FIXED/INCR bursts (WRAP handled as INCR),
// one outstanding transaction per direction, independent read and write FSMs.
//   clk_i, rstn_i : clock and asynchronous active-low reset
//   axi_sub_if    : AXI_BUS.Slave port carrying all AW/W/B/AR/R signals
// Optional macro AXI4_SUB_ERR_EN: out-of-range beats, WRAP bursts and w_last mismatches
// respond SLVERR; otherwise every response is OKAY and addresses wrap modulo MEM_DEPTH.
module axi4_sub_mem
    import axi4_sub_pkg::*;
#(
    parameter int unsigned               AXI_ADDR_WIDTH = 32,
    parameter int unsigned               AXI_DATA_WIDTH = 64,
    parameter int unsigned               AXI_ID_WIDTH   = 4,
    parameter int unsigned               AXI_USER_WIDTH = 1,
    parameter int unsigned               MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input logic   clk_i,
    input logic   rstn_i,
    AXI_BUS.Slave axi_sub_if
);
    localparam int unsigned NB    = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned SPAN  = NB * MEM_DEPTH;

    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef logic [AXI_DATA_WIDTH-1:0] data_t;
    typedef logic [AXI_ID_WIDTH-1:0]   id_t;
    typedef logic [IDX_W-1:0]          idx_t;

    function automatic idx_t word_idx(input addr_t a);
        addr_t off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    function automatic addr_t beat_step(input logic [BURST_W-1:0] burst);
        return (burst == BURST_FIXED) ? '0 : addr_t'(NB);
    endfunction

    // Write channel state
    wr_state_t          wr_state;
    addr_t              wr_addr;
    logic [LEN_W-1:0]   wr_len;
    logic [LEN_W-1:0]   wr_cnt;
    logic [BURST_W-1:0] wr_burst;
    id_t                wr_id;
    logic               wr_err;
    logic               aw_ready;
    logic               w_ready;
    logic               b_valid;
    logic [RESP_W-1:0]  b_resp;
    id_t                b_id;

    // Read channel state
    rd_state_t          rd_state;
    addr_t              rd_addr;
    logic [LEN_W-1:0]   rd_len;
    logic [LEN_W-1:0]   rd_cnt;
    logic [BURST_W-1:0] rd_burst;
    logic               ar_ready;
    logic               r_valid;
    logic               r_last;
    logic [RESP_W-1:0]  r_resp;
    id_t                r_id;
    data_t              r_data;

    logic               aw_hs_c;
    logic               w_hs_c;
    logic               ar_hs_c;
    logic               wr_last_beat_c;
    logic               wr_skip_c;
    logic               wr_beat_err_c;
    logic               mem_we_c;
    addr_t              rd_next_addr_c;
    logic [BURST_W-1:0] rd_next_burst_c;
    logic               rd_skip_c;
    data_t              mem_rdata_c;
    data_t              rd_beat_data_c;
    idx_t               wr_idx_c;
    idx_t               rd_idx_c;
    logic               unused_ok;

    assign aw_hs_c        = aw_ready & axi_sub_if.aw_valid;
    assign w_hs_c         = w_ready & axi_sub_if.w_valid;
    assign ar_hs_c        = ar_ready & axi_sub_if.ar_valid;
    assign wr_last_beat_c = (wr_cnt == wr_len);

    // Address of the beat that the next r_data register load will present
    always_comb begin
        rd_next_addr_c  = axi_sub_if.ar_addr;
        rd_next_burst_c = axi_sub_if.ar_burst;
        if (rd_state == RD_DATA) begin
            rd_next_addr_c  = rd_addr + beat_step(rd_burst);
            rd_next_burst_c = rd_burst;
        end
    end

`ifdef AXI4_SUB_ERR_EN
    function automatic logic in_range(input addr_t a);
        addr_t off;
        off = a - BASE_ADDR;
        return off < addr_t'(SPAN);
    endfunction

    // Skipped beats perform no memory access; a w_last mismatch only flags the response
    assign wr_skip_c     = !in_range(wr_addr) || (wr_burst == BURST_WRAP);
    assign wr_beat_err_c = wr_skip_c || (axi_sub_if.w_last != wr_last_beat_c);
    assign rd_skip_c     = !in_range(rd_next_addr_c) || (rd_next_burst_c == BURST_WRAP);
    assign unused_ok     = ^{axi_sub_if.aw_size, axi_sub_if.ar_size};
`else
    assign wr_skip_c     = 1'b0;
    assign wr_beat_err_c = 1'b0;
    assign rd_skip_c     = 1'b0;
    assign unused_ok     = ^{axi_sub_if.aw_size, axi_sub_if.ar_size, axi_sub_if.w_last,
                             rd_next_burst_c};
`endif

    assign mem_we_c       = w_hs_c & ~wr_skip_c;
    assign wr_idx_c       = word_idx(wr_addr);
    assign rd_idx_c       = word_idx(rd_next_addr_c);
    assign rd_beat_data_c = rd_skip_c ? '0 : mem_rdata_c;

    axi4_sub_mem_array #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .MEM_DEPTH      (MEM_DEPTH)
    ) u_array (
        .clk    (clk_i),
        .we     (mem_we_c),
        .w_idx  (wr_idx_c),
        .w_data (axi_sub_if.w_data),
        .w_strb (axi_sub_if.w_strb),
        .r_idx  (rd_idx_c),
        .r_data (mem_rdata_c)
    );

    // Write FSM: the beat count alone terminates the burst
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_state <= WR_IDLE;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_burst <= BURST_INCR;
            wr_id    <= '0;
            wr_err   <= 1'b0;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            b_id     <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs_c) begin
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        wr_addr  <= axi_sub_if.aw_addr;
                        wr_len   <= axi_sub_if.aw_len;
                        wr_burst <= axi_sub_if.aw_burst;
                        wr_id    <= axi_sub_if.aw_id;
                        wr_cnt   <= '0;
                        wr_err   <= 1'b0;
                        wr_state <= WR_DATA;
                    end else begin
                        aw_ready <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_hs_c) begin
                        wr_addr <= wr_addr + beat_step(wr_burst);
                        wr_cnt  <= wr_cnt + LEN_W'(1);
                        wr_err  <= wr_err | wr_beat_err_c;
                        if (wr_last_beat_c) begin
                            w_ready  <= 1'b0;
                            b_valid  <= 1'b1;
                            b_id     <= wr_id;
                            b_resp   <= resp_of(wr_err | wr_beat_err_c);
                            wr_state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_sub_if.b_ready) begin
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read FSM: r_data/r_last/r_resp reload only on AR or R handshakes, so they hold under stall
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            rd_burst <= BURST_INCR;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_resp   <= RESP_OKAY;
            r_id     <= '0;
            r_data   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs_c) begin
                        ar_ready <= 1'b0;
                        r_valid  <= 1'b1;
                        r_data   <= rd_beat_data_c;
                        r_resp   <= resp_of(rd_skip_c);
                        r_last   <= (axi_sub_if.ar_len == '0);
                        r_id     <= axi_sub_if.ar_id;
                        rd_addr  <= axi_sub_if.ar_addr;
                        rd_len   <= axi_sub_if.ar_len;
                        rd_burst <= axi_sub_if.ar_burst;
                        rd_cnt   <= '0;
                        rd_state <= RD_DATA;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (axi_sub_if.r_ready) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            ar_ready <= 1'b1;
                            rd_state <= RD_IDLE;
                        end else begin
                            rd_addr <= rd_next_addr_c;
                            rd_cnt  <= rd_cnt + LEN_W'(1);
                            r_data  <= rd_beat_data_c;
                            r_resp  <= resp_of(rd_skip_c);
                            r_last  <= ((rd_cnt + LEN_W'(1)) == rd_len);
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign axi_sub_if.aw_ready = aw_ready;
    assign axi_sub_if.w_ready  = w_ready;
    assign axi_sub_if.b_valid  = b_valid;
    assign axi_sub_if.b_resp   = b_resp;
    assign axi_sub_if.b_id     = b_id;
    assign axi_sub_if.b_user   = '0;
    assign axi_sub_if.ar_ready = ar_ready;
    assign axi_sub_if.r_valid  = r_valid;
    assign axi_sub_if.r_last   = r_last;
    assign axi_sub_if.r_resp   = r_resp;
    assign axi_sub_if.r_id     = r_id;
    assign axi_sub_if.r_data   = r_data;
    assign axi_sub_if.r_user   = '0;

endmodule

// File: tb/tb_axi4_sub_mem.sv
// Randomized self-checking bench for axi4_sub_mem against a word-array reference model.
// Honours AXI4_SUB_ERR_EN when defined for both the DUT and the bench.
module tb_axi4_sub_mem;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 64;
    localparam int unsigned IW    = 4;
    localparam int unsigned UW    = 1;
    localparam int unsigned DEPTH = 256;
`ifdef AXI4_SUB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) bus ();

    axi4_sub_mem #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .AXI_USER_WIDTH (UW),
        .MEM_DEPTH      (DEPTH),
        .BASE_ADDR      (32'h0)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .axi_sub_if (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] model [DEPTH];
    logic [63:0] wd_q [$];
    logic [7:0]  ws_q [$];
    logic [63:0] last_rdata;
    logic [1:0]  last_rresp;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 3) & 32'h0000_00FF);
    endfunction

    function automatic logic [31:0] step_of(input logic [1:0] burst);
        return (burst == FIXED) ? 32'd0 : 32'd8;
    endfunction

    function automatic bit beat_err(input logic [31:0] a, input logic [1:0] burst);
        return ERR_EN && ((a >= 32'h800) || (burst == WRAP));
    endfunction

    // Full write transaction; abort_beat >= 0 asserts reset while that beat is offered
    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [3:0] id, input bit bad_last, input int abort_beat);
        logic [31:0] a;
        bit          err;
        int          t;
        logic [63:0] d;
        logic [7:0]  s;
        bit          lastb;
        a   = addr;
        err = 1'b0;
        bus.aw_addr  = addr;
        bus.aw_len   = 8'(len);
        bus.aw_burst = burst;
        bus.aw_id    = id;
        bus.aw_size  = 3'd3;
        bus.aw_valid = 1'b1;
        t = 0;
        while (bus.aw_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check("aw_ready", 64'(bus.aw_ready), 64'd1);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        check("w_ready_after_aw", 64'(bus.w_ready), 64'd1);
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            d = (wd_q.size() > 0) ? wd_q.pop_front() : {$urandom, $urandom};
            s = (ws_q.size() > 0) ? ws_q.pop_front() : 8'hFF;
            lastb = (i == len) && !bad_last;
            bus.w_data  = d;
            bus.w_strb  = s;
            bus.w_last  = lastb;
            bus.w_valid = 1'b1;
            if (i == abort_beat) begin
                #2;
                rstn = 1'b0;
                #1;
                check("abort_aw_ready", 64'(bus.aw_ready), 64'd0);
                check("abort_w_ready", 64'(bus.w_ready), 64'd0);
                check("abort_b_valid", 64'(bus.b_valid), 64'd0);
                bus.w_valid = 1'b0;
                return;
            end
            t = 0;
            while (bus.w_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            check("w_ready", 64'(bus.w_ready), 64'd1);
            @(posedge clk); #1;
            bus.w_valid = 1'b0;
            if (!beat_err(a, burst)) begin
                for (int b = 0; b < 8; b++) begin
                    if (s[b]) model[widx(a)][b*8 +: 8] = d[b*8 +: 8];
                end
            end
            err = err || beat_err(a, burst) || (ERR_EN && (lastb != (i == len)));
            a = a + step_of(burst);
        end
        check("b_valid", 64'(bus.b_valid), 64'd1);
        check("b_resp", 64'(bus.b_resp), err ? 64'd2 : 64'd0);
        check("b_id", 64'(bus.b_id), 64'(id));
        check("w_ready_after_last", 64'(bus.w_ready), 64'd0);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check("b_hold", 64'(bus.b_valid), 64'd1);
        end
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        check("b_done", 64'(bus.b_valid), 64'd0);
    endtask

    // Full read transaction; mode 0 = always ready, 1 = random ready, 2 = alternating ready
    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [3:0] id, input int mode);
        logic [31:0] a;
        int          t;
        int          phase;
        bit          rdy;
        bit          e;
        logic [63:0] exp;
        logic [63:0] prev;
        a     = addr;
        phase = 0;
        bus.ar_addr  = addr;
        bus.ar_len   = 8'(len);
        bus.ar_burst = burst;
        bus.ar_id    = id;
        bus.ar_size  = 3'd3;
        bus.ar_valid = 1'b1;
        t = 0;
        while (bus.ar_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check("ar_ready", 64'(bus.ar_ready), 64'd1);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        check("r_valid_first", 64'(bus.r_valid), 64'd1);
        for (int i = 0; i <= len; i++) begin
            e   = beat_err(a, burst);
            exp = e ? 64'd0 : model[widx(a)];
            t   = 0;
            do begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = (phase % 2) == 0;
                endcase
                if (t >= 20) rdy = 1'b1;
                bus.r_ready = rdy;
                check("r_valid", 64'(bus.r_valid), 64'd1);
                check("r_data", bus.r_data, exp);
                check("r_last", 64'(bus.r_last), (i == len) ? 64'd1 : 64'd0);
                check("r_resp", 64'(bus.r_resp), e ? 64'd2 : 64'd0);
                check("r_id", 64'(bus.r_id), 64'(id));
                prev       = bus.r_data;
                last_rdata = bus.r_data;
                last_rresp = bus.r_resp;
                @(posedge clk); #1;
                if (!rdy) check("r_hold", bus.r_data, prev);
                t++;
                phase++;
            end while (!rdy);
            a = a + step_of(burst);
        end
        bus.r_ready = 1'b0;
        check("r_done", 64'(bus.r_valid), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op;
        int          len;
        logic [1:0]  burst;
        logic [3:0]  id;
        logic [31:0] wa;
        logic [31:0] ra;

        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
        bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
        bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        check("rst_w_ready", 64'(bus.w_ready), 64'd0);
        check("rst_b_valid", 64'(bus.b_valid), 64'd0);
        check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        check("rst_r_valid", 64'(bus.r_valid), 64'd0);
        check("rst_r_last", 64'(bus.r_last), 64'd0);
        check("rst_b_resp", 64'(bus.b_resp), 64'd0);
        check("rst_r_resp", 64'(bus.r_resp), 64'd0);
        check("rst_b_id", 64'(bus.b_id), 64'd0);
        check("rst_r_id", 64'(bus.r_id), 64'd0);
        check("rst_r_data", bus.r_data, 64'd0);
        rstn = 1'b1;
        check("aw_ready_pre_edge", 64'(bus.aw_ready), 64'd0);
        @(posedge clk); #1;
        check("aw_ready_rise", 64'(bus.aw_ready), 64'd1);
        check("ar_ready_rise", 64'(bus.ar_ready), 64'd1);

        // Fill every word so later reads have known contents
        do_write(32'h0, 255, INCR, 4'd0, 1'b0, -1);

        // Single write then read
        wd_q.push_back(64'hDEADBEEF_01234567);
        do_write(32'h10, 0, INCR, 4'd1, 1'b0, -1);
        do_read(32'h10, 0, INCR, 4'd1, 0);
        check("single_data", last_rdata, 64'hDEADBEEF_01234567);

        // INCR burst with 1,0,1 ready pattern
        for (int k = 1; k <= 4; k++) wd_q.push_back(64'(k));
        do_write(32'h0, 3, INCR, 4'd2, 1'b0, -1);
        do_read(32'h0, 3, INCR, 4'd2, 2);
        check("incr_last_data", last_rdata, 64'd4);

        // Byte strobes
        wd_q.push_back(64'hFFFF_FFFF_FFFF_FFFF); ws_q.push_back(8'hFF);
        do_write(32'h8, 0, INCR, 4'd3, 1'b0, -1);
        wd_q.push_back(64'h0); ws_q.push_back(8'h0F);
        do_write(32'h8, 0, INCR, 4'd3, 1'b0, -1);
        do_read(32'h8, 0, INCR, 4'd3, 0);
        check("strobe_data", last_rdata, 64'hFFFF_FFFF_0000_0000);

        // Concurrent write and read on disjoint words
        fork
            do_write(32'h40, 3, INCR, 4'd3, 1'b0, -1);
            do_read(32'h80, 3, INCR, 4'd5, 1);
        join
        do_read(32'h40, 3, INCR, 4'd3, 0);

        // Out-of-range read
        do_read(32'h800, 0, INCR, 4'd6, 0);
        check("oob_resp", 64'(last_rresp), ERR_EN ? 64'd2 : 64'd0);

        // Burst running off the end of memory, FIXED, WRAP, bad w_last
        do_write(32'h7F0, 3, INCR, 4'd7, 1'b0, -1);
        do_read(32'h7F0, 3, INCR, 4'd7, 1);
        do_read(32'h0, 1, INCR, 4'd7, 0);
        do_write(32'h100, 3, FIXED, 4'd8, 1'b0, -1);
        do_read(32'h100, 2, FIXED, 4'd8, 1);
        do_write(32'h200, 1, WRAP, 4'd9, 1'b0, -1);
        do_read(32'h200, 1, WRAP, 4'd9, 0);
        do_write(32'h300, 1, INCR, 4'd4, 1'b1, -1);
        do_write(32'h310, 0, INCR, 4'd4, 1'b1, -1);
        do_read(32'h300, 2, INCR, 4'd4, 0);

        // Reset during beat 2 of a 4-beat write
        do_write(32'h180, 3, INCR, 4'd10, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1;
        check("abort_r_valid", 64'(bus.r_valid), 64'd0);
        rstn = 1'b1;
        check("post_abort_aw_low", 64'(bus.aw_ready), 64'd0);
        @(posedge clk); #1;
        check("post_abort_aw_rise", 64'(bus.aw_ready), 64'd1);
        check("post_abort_no_b", 64'(bus.b_valid), 64'd0);
        do_read(32'h180, 3, INCR, 4'd10, 0);
        do_write(32'h180, 3, INCR, 4'd11, 1'b0, -1);
        do_read(32'h180, 3, INCR, 4'd11, 1);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            op    = int'($urandom_range(0, 2));
            len   = int'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 2));
            id    = 4'($urandom);
            if (op == 0) begin
                for (int k = 0; k <= len; k++) ws_q.push_back(8'($urandom));
                do_write(32'($urandom_range(0, 255)) << 3, len, burst, id, 1'b0, -1);
            end else if (op == 1) begin
                do_read(32'($urandom_range(0, 255)) << 3, len, burst, id, 1);
            end else begin
                wa = 32'($urandom_range(0, 100)) << 3;
                ra = 32'($urandom_range(128, 230)) << 3;
                fork
                    do_write(wa, len, burst, id, 1'b0, -1);
                    do_read(ra, len, burst, ~id, 1);
                join
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
